// File: rtl/data_memory_banked.sv
// Byte-banked data memory with load/store sizing, alignment checks and a
// self-clearing start-up sequence. Each byte lane is its own bank so stores
// touch only the addressed lanes; the debug bus exports the low words live.

// One byte-wide bank: DEPTH bytes, write on enable, contents visible in full.
module data_memory_lane #(
  parameter int ADDR_WIDTH = 4,
  localparam int DEPTH = 2 ** ADDR_WIDTH
) (
  input  logic                          writeClk,
  input  logic                          we,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [7:0]                    wdata,
  output logic [DEPTH-1:0][7:0]         q
);
  // Byte write into the bank; no reset, the clear sequence zeroes storage.
  always_ff @(posedge writeClk) begin
    if (we) q[waddr] <= wdata;
  end
endmodule

module data_memory_banked #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int DEBUG_WORDS = 10,
  localparam int DEPTH = 2 ** ADDR_WIDTH,
  localparam int BYTES = DATA_WIDTH / 8,
  localparam int LB    = $clog2(BYTES),
  localparam int BA    = ADDR_WIDTH + LB
) (
  input  logic                            writeClk,
  input  logic                            reset,
  input  logic                            clkEnable,
  input  logic                            req,
  input  logic                            we,
  input  logic [1:0]                      size,
  input  logic                            uns,
  input  logic [BA-1:0]                   addr,
  input  logic [DATA_WIDTH-1:0]           din,
  output logic [DATA_WIDTH-1:0]           dout,
  output logic                            rvalid,
  output logic                            err,
  output logic                            busy,
  output logic [DEBUG_WORDS*DATA_WIDTH-1:0] memorias
);
  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_cnt;

  logic [LB-1:0]           off;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [3:0]              nbytes;
  logic                    misalign, bad, accept, st_ok, ld_ok;
  logic [BYTES-1:0]        bsel;
  logic [DATA_WIDTH-1:0]   st_data;

  logic [BYTES-1:0]               lane_we;
  logic [ADDR_WIDTH-1:0]          lane_addr;
  logic [BYTES-1:0][7:0]          lane_wd;
  logic [BYTES-1:0][DEPTH-1:0][7:0] lane_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] words;

  logic [DATA_WIDTH-1:0]   rd_shift, fmask, ld_val;
  logic                    sbit;

  assign off    = addr[LB-1:0];
  assign waddr  = addr[BA-1:LB];
  assign nbytes = 4'd1 << size;

  // Alignment: any low offset bit inside the access size is illegal; dword
  // accesses are meaningless on a 32-bit memory.
  assign misalign = |(off & LB'(nbytes - 4'd1));
  assign bad      = misalign | ((size == 2'b11) && (DATA_WIDTH == 32));
  assign accept   = req & clkEnable & (state == S_IDLE) & ~reset;
  assign st_ok    = accept & we & ~bad;
  assign ld_ok    = accept & ~we & ~bad;

  // Store data is right-aligned on din; move it up to the addressed lanes.
  assign st_data = din << {off, 3'b000};

  // Lane select: lanes off .. off+nbytes-1 take part in a store.
  always_comb begin
    bsel = '0;
    for (int i = 0; i < BYTES; i++)
      bsel[i] = (i >= int'(off)) && (i < int'(off) + int'(nbytes));
  end

  // Bank write port mux: the clear sequence owns the banks while busy.
  always_comb begin
    lane_we   = '0;
    lane_addr = waddr;
    lane_wd   = st_data;
    if (!reset && state == S_CLEAR) begin
      lane_we   = '1;
      lane_addr = clr_cnt;
      lane_wd   = '0;
    end else if (st_ok) begin
      lane_we   = bsel;
    end
  end

  for (genvar i = 0; i < BYTES; i++) begin : g_lane
    data_memory_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .writeClk (writeClk),
      .we       (lane_we[i]),
      .waddr    (lane_addr),
      .wdata    (lane_wd[i]),
      .q        (lane_q[i])
    );
  end

  // Reassemble little-endian words from the byte banks.
  always_comb begin
    words = '0;
    for (int k = 0; k < DEPTH; k++)
      for (int i = 0; i < BYTES; i++)
        words[k][i*8 +: 8] = lane_q[i][k];
  end

  // Debug export: word 0 lands in the most significant slot.
  always_comb begin
    memorias = '0;
    for (int k = 0; k < DEBUG_WORDS; k++)
      memorias[(DEBUG_WORDS-1-k)*DATA_WIDTH +: DATA_WIDTH] = words[k];
  end

  // Load field extraction: shift addressed bytes down, then mask and extend.
  always_comb begin
    rd_shift = words[waddr] >> {off, 3'b000};
    fmask    = '1;
    sbit     = 1'b0;
    case (size)
      2'b00:   begin fmask = DATA_WIDTH'(8'hFF);          sbit = rd_shift[7];  end
      2'b01:   begin fmask = DATA_WIDTH'(16'hFFFF);       sbit = rd_shift[15]; end
      2'b10:   begin fmask = DATA_WIDTH'(32'hFFFF_FFFF);  sbit = rd_shift[31]; end
      default: begin fmask = '1;                          sbit = 1'b0;         end
    endcase
    ld_val = (rd_shift & fmask) | ((sbit & ~uns) ? ~fmask : '0);
  end

  // Controller state register.
  always_ff @(posedge writeClk) begin
    if (reset) state <= S_CLEAR;
    else       state <= state_nxt;
  end

  // Leave CLEAR once the last word has been zeroed.
  always_comb begin
    state_nxt = state;
    if (state == S_CLEAR && clr_cnt == ADDR_WIDTH'(DEPTH - 1)) state_nxt = S_IDLE;
  end

  // Controller outputs.
  always_comb begin
    busy = (state == S_CLEAR);
  end

  // Clear counter walks every word once; it wraps back to 0 on exit.
  always_ff @(posedge writeClk) begin
    if (reset)                 clr_cnt <= '0;
    else if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
    else                       clr_cnt <= '0;
  end

  // Response register: one-cycle rvalid/err pulses, dout held between loads.
  always_ff @(posedge writeClk) begin
    if (reset) begin
      dout   <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      rvalid <= ld_ok;
      err    <= accept & bad;
      if (ld_ok) dout <= ld_val;
    end
  end
endmodule

// File: tb/tb_data_memory_banked.sv
// Scoreboard bench for data_memory_banked: byte-array reference model,
// directed corner cases plus randomized traffic.
module tb_data_memory_banked;
  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int DBG = 10;

  logic              writeClk = 1'b0;
  logic              reset = 1'b1, clkEnable = 1'b0, req = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]        size = 2'b00;
  logic [5:0]        addr = '0;
  logic [DW-1:0]     din = '0;
  logic [DW-1:0]     dout;
  logic              rvalid, err, busy;
  logic [DBG*DW-1:0] memorias;

  data_memory_banked #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEBUG_WORDS(DBG)) dut (
    .writeClk (writeClk), .reset (reset), .clkEnable (clkEnable), .req (req),
    .we (we), .size (size), .uns (uns), .addr (addr), .din (din),
    .dout (dout), .rvalid (rvalid), .err (err), .busy (busy), .memorias (memorias)
  );

  always #5 writeClk = ~writeClk;

  typedef struct { bit is_err; logic [31:0] data; } exp_t;

  byte unsigned mm [64];
  logic [31:0]  mdout = '0;
  bit           clearing = 1'b1;
  exp_t         sb_q [$];
  int           n_tests = 0, n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Issue one request for one cycle and predict the response from the model.
  task automatic op(input bit w, input logic [1:0] sz, input bit u, input logic [5:0] a,
                    input logic [31:0] d, input bit ce);
    exp_t e;
    int nb;
    logic [63:0] v, m;
    @(negedge writeClk);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; din = d; clkEnable = ce;
    @(posedge writeClk);
    #1;
    req = 1'b0;
    if (!ce || clearing) return;
    nb = 1 << sz;
    if ((int'(a) % nb) != 0 || sz == 2'd3) begin
      e.is_err = 1'b1; e.data = mdout; sb_q.push_back(e);
      return;
    end
    if (w) begin
      for (int b = 0; b < nb; b++) mm[int'(a) + b] = d[8*b +: 8];
    end else begin
      v = '0;
      for (int b = 0; b < nb; b++) v |= 64'(mm[int'(a) + b]) << (8*b);
      m = (64'd1 << (8*nb)) - 64'd1;
      if (!u && v[8*nb-1]) v |= ~m;
      mdout = v[31:0];
      e.is_err = 1'b0; e.data = mdout; sb_q.push_back(e);
    end
  endtask

  // Monitor: every response must match the oldest prediction, on time.
  exp_t me;
  always @(negedge writeClk) begin
    if (rvalid || err) begin
      if (sb_q.size() == 0) check("unexpected_resp", {rvalid, err}, 2'b00);
      else begin
        me = sb_q.pop_front();
        check("resp_kind", {rvalid, err}, me.is_err ? 2'b01 : 2'b10);
        check("resp_dout", dout, me.data);
      end
    end else if (sb_q.size() != 0) begin
      me = sb_q.pop_front();
      check("missing_resp", {rvalid, err}, me.is_err ? 2'b01 : 2'b10);
    end
  end

  task automatic do_reset(input int cyc);
    @(negedge writeClk);
    reset = 1'b1;
    repeat (cyc) @(posedge writeClk);
    clearing = 1'b1;
    mdout = '0;
    @(negedge writeClk);
    check("busy_in_reset", busy, 1'b1);
    reset = 1'b0;
  endtask

  // Count edges until busy falls; the clear leaves memory all zero.
  task automatic wait_clear(input int exp_edges, input string nm);
    int n = 0;
    while (busy && n < 100) begin
      @(posedge writeClk);
      @(negedge writeClk);
      n++;
    end
    check(nm, n, exp_edges);
    for (int i = 0; i < 64; i++) mm[i] = 8'h00;
    clearing = 1'b0;
  endtask

  task automatic check_mem(input string nm);
    for (int k = 0; k < DBG; k++)
      check($sformatf("%s_w%0d", nm, k), memorias[(DBG-1-k)*DW +: DW],
            {mm[4*k+3], mm[4*k+2], mm[4*k+1], mm[4*k]});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset(2);
    wait_clear(16, "busy_edges_after_reset");
    check("dout_after_reset", dout, 32'h0);
    check("rvalid_after_reset", rvalid, 1'b0);
    check("memorias_after_reset", memorias, '0);

    op(1, 2'd2, 0, 6'h08, 32'hDEADBEEF, 1);
    op(0, 2'd2, 0, 6'h08, 32'h0, 1);
    check("word2_after_sw", memorias[255:224], 32'hDEADBEEF);

    op(1, 2'd0, 0, 6'h09, 32'h00000080, 1);
    op(0, 2'd0, 0, 6'h09, 32'h0, 1);
    op(0, 2'd0, 1, 6'h09, 32'h0, 1);
    check("word2_after_sb", memorias[255:224], 32'hDEAD80EF);

    op(0, 2'd1, 0, 6'h0B, 32'h0, 1);
    op(1, 2'd2, 0, 6'h0A, 32'h11111111, 1);
    op(0, 2'd3, 0, 6'h08, 32'h0, 1);
    check("word2_after_errs", memorias[255:224], 32'hDEAD80EF);

    op(1, 2'd2, 0, 6'h04, 32'h12345678, 0);
    @(negedge writeClk);
    check("word1_ce_low", memorias[287:256], 32'h0);

    // Request held for the whole clear sequence is ignored.
    do_reset(2);
    req = 1'b1; we = 1'b1; size = 2'd2; addr = 6'h04; din = 32'h12345678; clkEnable = 1'b1;
    wait_clear(16, "busy_edges_req_held");
    req = 1'b0;
    check("word1_busy_drop", memorias[287:256], 32'h0);

    // Reset in the middle of the clear restarts it from word 0.
    do_reset(2);
    repeat (7) @(posedge writeClk);
    @(negedge writeClk);
    reset = 1'b1;
    @(posedge writeClk);
    @(negedge writeClk);
    check("busy_mid_clear_reset", busy, 1'b1);
    reset = 1'b0;
    wait_clear(16, "busy_edges_restart");

    for (int i = 0; i < 300; i++)
      op($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
         6'($urandom_range(0, 63)), $urandom, $urandom_range(0, 9) != 0);
    @(negedge writeClk);
    check_mem("rand");

    do_reset(1);
    wait_clear(16, "busy_edges_idle_reset");
    check_mem("cleared");
    check("dout_idle_reset", dout, 32'h0);
    check("queue_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/data_memory_banked.md
DATA_MEMORY_BANKED -- requirements
Module: data_memory_banked

Interface
REQ-001 The parameters SHALL be:
  - DATA_WIDTH, default 32, word width in bits; legal values 32 or 64.
  - ADDR_WIDTH, default 4, word-address bits; depth DEPTH = 2**ADDR_WIDTH.
  - DEBUG_WORDS, default 10, number of words exported on memorias; 1..DEPTH.
REQ-002 Derived values: BYTES = DATA_WIDTH/8; BA = ADDR_WIDTH + log2(BYTES) byte-address bits.
REQ-003 The ports SHALL be (name, direction, width, meaning):
  - writeClk  in  1  clock; all state changes on its rising edge.
  - reset  in  1  synchronous, active-high.
  - clkEnable  in  1  qualifies request acceptance.
  - req  in  1  access request.
  - we  in  1  1 = store, 0 = load.
  - size  in  2  access size: 00 byte, 01 half, 10 word32, 11 dword (legal only when DATA_WIDTH=64).
  - uns  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
  - addr  in  BA  byte address.
  - din  in  DATA_WIDTH  store data, right-aligned.
  - dout  out  DATA_WIDTH  registered load result.
  - rvalid  out  1  one-cycle pulse, load result valid.
  - err  out  1  one-cycle pulse, rejected access.
  - busy  out  1  clear sequence in progress.
  - memorias  out  DEBUG_WORDS*DATA_WIDTH  live contents of words 0..DEBUG_WORDS-1; word 0 in the MSBs.
REQ-004 Reset SHALL be reset: synchronous, active-high; the clock SHALL be writeClk.

Function
REQ-005 The controller SHALL have two states, CLEAR and IDLE, with a clear counter clr_cnt of ADDR_WIDTH bits.
REQ-006 CLEAR behaviour SHALL be:
  - On each writeClk edge with reset=0, write zero to word clr_cnt, then increment clr_cnt.
  - After word DEPTH-1 is written, transition to IDLE.
  - Clearing SHALL proceed regardless of clkEnable.
REQ-007 busy SHALL be 1 exactly while the state is CLEAR.
REQ-008 A request SHALL be accepted only when req=1, clkEnable=1 and state=IDLE.
REQ-009 A request presented while busy=1 or clkEnable=0 SHALL be dropped silently: no memory change, rvalid=0, err=0.
REQ-010 Byte lane ordering SHALL be little-endian within a word: addr[log2(BYTES)-1:0]=0 selects bits [7:0].
REQ-011 An accepted access SHALL be rejected (err=1 on the next cycle) when either:
  - addr is not a multiple of the access size in bytes, or
  - size=11 and DATA_WIDTH=32.
  A rejected access SHALL leave memory unchanged, keep rvalid=0 and leave dout unchanged.
REQ-012 An accepted legal store SHALL update only the addressed byte lanes, taken from the low-order bytes of din; all other lanes are preserved.
REQ-013 An accepted legal load SHALL, on the following edge:
  - register the extracted field into dout, sign- or zero-extended per uns (size equal to DATA_WIDTH: no extension);
  - pulse rvalid=1 for one cycle.
REQ-014 dout SHALL hold its value until the next accepted legal load.
REQ-015 A load issued in the cycle immediately after a store to the same word SHALL return the updated data.
REQ-016 rvalid and err SHALL never be 1 in the same cycle.
REQ-017 memorias SHALL reflect memory contents continuously: word k occupies bits [(DEBUG_WORDS-k)*DATA_WIDTH-1 : (DEBUG_WORDS-k-1)*DATA_WIDTH].

Reset
REQ-018 While reset=1 on an edge, the block SHALL:
  - set state=CLEAR, clr_cnt=0, dout=0, rvalid=0, err=0;
  - not write memory.
REQ-019 busy SHALL read 1 from the first edge with reset=1 and SHALL stay 1 for DEPTH edges after reset deasserts.
REQ-020 Reset asserted during CLEAR SHALL restart the clear sequence at word 0.
REQ-021 Reset asserted during IDLE SHALL discard any in-flight load result (rvalid forced 0).

Verification (DATA_WIDTH=32, ADDR_WIDTH=4, DEBUG_WORDS=10)
REQ-022 The bench SHALL cover the following directed scenarios:
  - Hold reset 2 cycles, then release -> busy=1 for 16 edges then 0; memorias=0; dout=0; rvalid=0.
  - sw 0xDEADBEEF @0x08, then lw @0x08 -> next cycle rvalid=1, dout=0xDEADBEEF; memorias[255:224]=0xDEADBEEF.
  - sb 0x80 @0x09; lb @0x09 -> dout=0xFFFFFF80; lbu @0x09 -> dout=0x00000080; word 2 reads 0xDEAD80EF.
  - lh @0x0B -> err=1 for 1 cycle, rvalid=0, dout unchanged; sw @0x0A -> err=1, word 2 unchanged; size=11 -> err=1.
  - req=1 with clkEnable=0 (store 0x12345678 @0x04) -> word 1 stays 0; err=0; a request during busy is likewise dropped.
  - Reset pulse when clr_cnt=7 -> busy stays 1 for 16 further edges; reset after writes in IDLE -> all words 0 once busy falls.
